// File: rtl/gap_det_pkg.sv
// Shared types for the multi-channel serial gap detector.
package gap_det_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/gap_detector_ch.sv
// One serial channel: arm on '1', count the zero run, report on the closing '1'.
module gap_detector_ch
  import gap_det_pkg::*;
#(
  parameter int CNT_W   = 3,
  parameter int SAT_GAP = 4,
  parameter bit OVERLAP = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  input  logic [CNT_W-1:0] eff_min,
  output logic             rep,
  output logic             valid,
  output logic [CNT_W-1:0] gap_len,
  output logic             sat
);

  localparam logic [CNT_W-1:0] SAT_V = CNT_W'(SAT_GAP);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Report decision of this edge, also consumed by the shared event counter.
  assign rep = en && (state == GAP) && x && (cnt >= eff_min);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      valid   <= 1'b0;
      gap_len <= '0;
      sat     <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (en) begin
        unique case (state)
          IDLE: begin
            if (x) state <= ARMED;
          end
          ARMED: begin
            if (!x) begin
              state <= GAP;
              cnt   <= ONE;
            end
          end
          GAP: begin
            if (!x) begin
              if (cnt < SAT_V) cnt <= cnt + ONE;
            end else begin
              cnt <= '0;
              if (rep) begin
                valid   <= 1'b1;
                gap_len <= cnt;
                sat     <= (cnt == SAT_V);
                state   <= OVERLAP ? ARMED : IDLE;
              end else begin
                state <= ARMED;
              end
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/multi_gap_detector.sv
// Multi-channel gap detector: per-channel FSMs plus a shared report counter.
module multi_gap_detector
  import gap_det_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 3,
  parameter int SAT_GAP  = 4,
  parameter bit OVERLAP  = 1'b0,
  parameter int EVT_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [CHANNELS-1:0]       x,
  input  logic [CNT_W-1:0]          min_gap,
  input  logic                      evt_clr,
  output logic [CHANNELS-1:0]       valid,
  output logic [CHANNELS*CNT_W-1:0] gap_len,
  output logic [CHANNELS-1:0]       sat,
  output logic [EVT_W-1:0]          evt_cnt
);

  logic [CNT_W-1:0]    eff_min;
  logic [CHANNELS-1:0] rep;
  logic [EVT_W-1:0]    pop;

  // A zero threshold would let gap 0 through; clamp to 1.
  assign eff_min = (min_gap == '0) ? CNT_W'(1) : min_gap;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    gap_detector_ch #(
      .CNT_W   (CNT_W),
      .SAT_GAP (SAT_GAP),
      .OVERLAP (OVERLAP)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .x       (x[i]),
      .eff_min (eff_min),
      .rep     (rep[i]),
      .valid   (valid[i]),
      .gap_len (gap_len[i*CNT_W +: CNT_W]),
      .sat     (sat[i])
    );
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < CHANNELS; i++)
      pop = pop + EVT_W'(rep[i]);
  end

  always_ff @(posedge clk) begin
    if (rst || evt_clr) evt_cnt <= '0;
    else                evt_cnt <= evt_cnt + pop;
  end

endmodule
